// File: rtl/button_conditioner.sv
// Synchronises, debounces and edge-detects active-low push buttons into clean active-high levels and pulses.
// Optional auto-repeat of press_pulse while held is compiled in with `define BUTTON_REPEAT_EN.
module button_conditioner #(
  parameter int N_BUTTONS       = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] buttons_raw,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] release_pulse,
  output logic                 any_pressed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
      (CNT_W < 32 && (1 << CNT_W) <= DEBOUNCE_CYCLES) ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("button_conditioner: illegal parameter combination");
  end

  logic [N_BUTTONS-1:0] sync1;
  logic [N_BUTTONS-1:0] sync2;
  logic [N_BUTTONS-1:0] stable_q;
  logic [N_BUTTONS-1:0] stable_d;
  logic [N_BUTTONS-1:0] rise;
  logic [N_BUTTONS-1:0] fall;
  logic [N_BUTTONS-1:0] press_next;
  logic [CNT_W-1:0]     cnt_q [N_BUTTONS];
  logic [CNT_W-1:0]     cnt_d [N_BUTTONS];

  // A sample that matches stable restarts the count, so only an unbroken run can flip the level.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_BUTTONS; i++) begin
      cnt_d[i] = '0;
      if (sync2[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign rise = stable_d & ~stable_q;
  assign fall = ~stable_d & stable_q;

`ifdef BUTTON_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(REP_MAX) + 1;

  logic [TMR_W-1:0]     tmr_q [N_BUTTONS];
  logic [TMR_W-1:0]     tmr_d [N_BUTTONS];
  logic [N_BUTTONS-1:0] rep;

  // Down-counter per channel; terminal count fires a repeat and reloads with the period.
  always_comb begin
    for (int i = 0; i < N_BUTTONS; i++) begin
      tmr_d[i] = '0;
      rep[i]   = 1'b0;
      if (rise[i]) begin
        tmr_d[i] = TMR_W'(REPEAT_DELAY - 1);
      end else if (stable_q[i] && stable_d[i]) begin
        if (tmr_q[i] == '0) begin
          rep[i]   = 1'b1;
          tmr_d[i] = TMR_W'(REPEAT_PERIOD - 1);
        end else begin
          tmr_d[i] = tmr_q[i] - TMR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmr_q <= '{default: '0};
    end else begin
      tmr_q <= tmr_d;
    end
  end

  assign press_next = rise | rep;
`else
  assign press_next = rise;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= '0;
      sync2         <= '0;
      stable_q      <= '0;
      cnt_q         <= '{default: '0};
      press_pulse   <= '0;
      release_pulse <= '0;
      any_pressed   <= 1'b0;
    end else begin
      sync1         <= ~buttons_raw;
      sync2         <= sync1;
      stable_q      <= stable_d;
      cnt_q         <= cnt_d;
      press_pulse   <= press_next;
      release_pulse <= fall;
      any_pressed   <= |stable_q;
    end
  end

  assign pressed = stable_q;

endmodule
